exec_mem_reg: RTL

//  Execute-stage back end of the pipelined Y86-64 core. Sits directly downstream of the ALU.

---
 rtl/exec_mem_reg.sv | 110 +++++++++++
 1 files changed

// File: rtl/exec_mem_reg.sv
// Execute-stage back end: condition-code register, branch/cmov condition evaluation,
// cmov destination nulling, and the E->M pipeline register with stall/bubble control.
module exec_mem_reg #(
    parameter int unsigned W     = 64,
    parameter logic [3:0]  RNONE = 4'hF,
    parameter logic [3:0]  S_AOK = 4'h1,
    parameter logic [3:0]  S_HLT = 4'h2,
    parameter logic [3:0]  S_ADR = 4'h3,
    parameter logic [3:0]  S_INS = 4'h4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   e_icode,
    input  logic [3:0]   e_ifun,
    input  logic [3:0]   e_stat,
    input  logic [W-1:0] e_valE,
    input  logic [2:0]   e_ccnew,
    input  logic [W-1:0] e_valA,
    input  logic [3:0]   e_dstE,
    input  logic [3:0]   e_dstM,
    input  logic [3:0]   m_stat,
    input  logic [3:0]   W_stat,
    input  logic         M_stall,
    input  logic         M_bubble,
    output logic         e_cnd,
    output logic [2:0]   cc,
    output logic [3:0]   e_dstE_o,
    output logic [3:0]   M_stat,
    output logic [3:0]   M_icode,
    output logic [3:0]   M_dstE,
    output logic [3:0]   M_dstM,
    output logic         M_cnd,
    output logic [W-1:0] M_valE,
    output logic [W-1:0] M_valA
);

    localparam logic [3:0] I_NOP  = 4'h1;
    localparam logic [3:0] I_CMOV = 4'h2;
    localparam logic [3:0] I_OPQ  = 4'h6;
    localparam logic [2:0] CC_RST = 3'b100;

    logic zf, sf, of, lt;
    logic m_exc, w_exc, set_cc;

    assign zf = cc[2];
    assign sf = cc[1];
    assign of = cc[0];
    assign lt = sf ^ of;

    // Condition is taken from the architectural CC, not from this cycle's ALU flags
    always_comb begin
        e_cnd = 1'b0;
        case (e_ifun)
            4'h0:    e_cnd = 1'b1;
            4'h1:    e_cnd = lt | zf;
            4'h2:    e_cnd = lt;
            4'h3:    e_cnd = zf;
            4'h4:    e_cnd = ~zf;
            4'h5:    e_cnd = ~lt;
            4'h6:    e_cnd = ~lt & ~zf;
            default: e_cnd = 1'b0;
        endcase
    end

    assign e_dstE_o = (e_icode == I_CMOV && !e_cnd) ? RNONE : e_dstE;

    // An exception further down the pipe must not let a younger OPq change the CC
    assign m_exc  = (m_stat == S_HLT) || (m_stat == S_ADR) || (m_stat == S_INS);
    assign w_exc  = (W_stat == S_HLT) || (W_stat == S_ADR) || (W_stat == S_INS);
    assign set_cc = (e_icode == I_OPQ) && !M_stall && !m_exc && !w_exc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cc <= CC_RST;
        else if (set_cc)
            cc <= e_ccnew;
    end

    // E->M register: stall holds (and wins over bubble), bubble injects a nop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            M_stat  <= S_AOK;
            M_icode <= I_NOP;
            M_cnd   <= 1'b0;
            M_valE  <= '0;
            M_valA  <= '0;
            M_dstE  <= RNONE;
            M_dstM  <= RNONE;
        end else if (M_stall) begin
            M_stat  <= M_stat;
        end else if (M_bubble) begin
            M_stat  <= S_AOK;
            M_icode <= I_NOP;
            M_cnd   <= 1'b0;
            M_valE  <= '0;
            M_valA  <= '0;
            M_dstE  <= RNONE;
            M_dstM  <= RNONE;
        end else begin
            M_stat  <= e_stat;
            M_icode <= e_icode;
            M_cnd   <= e_cnd;
            M_valE  <= e_valE;
            M_valA  <= e_valA;
            M_dstE  <= e_dstE_o;
            M_dstM  <= e_dstM;
        end
    end

endmodule
